// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite bank: opcodes, control-word layout,
// FSM state encoding and the RGB444 -> RGBA8888 expansion.
package sprite_pkg;

  // Control-word field positions
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned IDX_MSB = 27;
  localparam int unsigned IDX_LSB = 20;
  localparam int unsigned X_MSB   = 19;
  localparam int unsigned X_LSB   = 16;
  localparam int unsigned Y_MSB   = 15;
  localparam int unsigned Y_LSB   = 12;
  localparam int unsigned PL_MSB  = 11;
  localparam int unsigned PL_LSB  = 0;

  typedef enum logic [3:0] {
    OP_WRITE  = 4'h1,
    OP_SELECT = 4'h2,
    OP_CLEAR  = 4'h3,
    OP_PERIOD = 4'h4,
    OP_FLIP   = 4'h5
  } opcode_e;

  // Control word as seen on the bus
  typedef struct packed {
    logic [OP_MSB-OP_LSB:0]   op;
    logic [IDX_MSB-IDX_LSB:0] index;
    logic [X_MSB-X_LSB:0]     x;
    logic [Y_MSB-Y_LSB:0]     y;
    logic [PL_MSB-PL_LSB:0]   payload;
  } ctrl_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // 4-bit channels land in the upper nibble, alpha is opaque
  function automatic logic [31:0] expand_rgb444(input logic [11:0] c);
    return {c[11:8], 4'h0, c[7:4], 4'h0, c[3:0], 4'h0, 8'hFF};
  endfunction

endpackage

// File: rtl/sprite_animator.sv
// Vsync-driven animation sequencer: holds the period and tick count and
// advances the displayed frame once every `period` vsync pulses.
module sprite_animator #(
  parameter int unsigned FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       period_we,
  input  logic [7:0] period_in,
  output logic [3:0] frame
);

  logic [7:0] period;
  logic [7:0] tick;
  logic [3:0] frame_next;

  assign frame_next = (frame + 4'd1) & 4'(FRAMES - 1);

  // Period register, tick counter and frame advance; a period write restarts the count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period <= 8'd1;
      tick   <= 8'd0;
      frame  <= 4'd0;
    end else if (period_we) begin
      period <= period_in;
      tick   <= 8'd0;
    end else if (vsync && (period != 8'd0)) begin
      if (tick == period - 8'd1) begin
        tick  <= 8'd0;
        frame <= frame_next;
      end else begin
        tick <= tick + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_bank.sv
// Per-sprite animation frame store with control-word command port,
// registered pixel read port and vsync frame sequencer.
// Optional build macro: SPRITE_FLIP_EN adds horizontal/vertical read mirroring.
module sprite_bank
  import sprite_pkg::*;
#(
  parameter int unsigned INDEX  = 0,
  parameter int unsigned SIZE   = 16,
  parameter int unsigned FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] control,
  input  logic        vsync,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  output logic [31:0] rgba,
  output logic [3:0]  frame
);

  localparam int unsigned PIX   = SIZE * SIZE;
  localparam int unsigned DEPTH = FRAMES * PIX;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = (PIX > 1) ? $clog2(PIX) : 1;

  ctrl_t   cw;
  opcode_e op;
  logic    hit;
  logic    wr_in_range;
  logic    rd_in_range;

  state_e        state, state_d;
  logic          cmd_ready_d;
  logic [CW-1:0] clr_cnt, clr_cnt_d;
  logic [3:0]    wr_frame;

  logic          mem_we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [AW-1:0] raddr;
  logic [3:0]    rx, ry;

  logic [31:0] mem [DEPTH];

  assign cw          = ctrl_t'(control);
  assign op          = opcode_e'(cw.op);
  assign hit         = cmd_valid && cmd_ready && (cw.index == 8'(INDEX));
  assign wr_in_range = (32'(cw.x) < SIZE) && (32'(cw.y) < SIZE);
  assign rd_in_range = (32'(x) < SIZE) && (32'(y) < SIZE);

  // FSM state, clear counter and ready registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_d;
      clr_cnt   <= clr_cnt_d;
      cmd_ready <= cmd_ready_d;
    end
  end

  // Next-state: CLEAR walks every pixel of wr_frame, ready returns after the last one
  always_comb begin
    state_d     = state;
    clr_cnt_d   = clr_cnt;
    cmd_ready_d = cmd_ready;
    case (state)
      IDLE: begin
        if (hit && (op == OP_CLEAR)) begin
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          cmd_ready_d = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_cnt == CW'(PIX - 1)) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt + CW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // Write-frame selection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_frame <= 4'd0;
    end else if (hit && (op == OP_SELECT)) begin
      wr_frame <= cw.payload[3:0] & 4'(FRAMES - 1);
    end
  end

  // Single write port shared by CLEAR sweep and WRITE commands; reset blocks the write
  always_comb begin
    mem_we = 1'b0;
    waddr  = '0;
    wdata  = '0;
    if (state == CLEAR) begin
      mem_we = reset_n;
      waddr  = AW'(32'(wr_frame) * PIX + 32'(clr_cnt));
    end else if (hit && (op == OP_WRITE) && wr_in_range) begin
      mem_we = reset_n;
      waddr  = AW'(32'(wr_frame) * PIX + 32'(cw.y) * SIZE + 32'(cw.x));
      wdata  = expand_rgb444(cw.payload);
    end
  end

`ifdef SPRITE_FLIP_EN
  logic flip_h, flip_v;

  // Mirror flags set by FLIP
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flip_h <= 1'b0;
      flip_v <= 1'b0;
    end else if (hit && (op == OP_FLIP)) begin
      flip_h <= cw.payload[0];
      flip_v <= cw.payload[1];
    end
  end

  // Read coordinates mirrored after the range check
  always_comb begin
    rx = flip_h ? 4'(SIZE - 1 - 32'(x)) : x;
    ry = flip_v ? 4'(SIZE - 1 - 32'(y)) : y;
  end
`else
  // Read coordinates pass straight through
  always_comb begin
    rx = x;
    ry = y;
  end
`endif

  assign raddr = AW'(32'(frame) * PIX + 32'(ry) * SIZE + 32'(rx));

  // Pixel memory write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read, read-before-write, out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgba <= 32'h0;
    end else begin
      rgba <= rd_in_range ? mem[raddr] : 32'h0;
    end
  end

  sprite_animator #(
    .FRAMES (FRAMES)
  ) u_anim (
    .clk       (clk),
    .reset_n   (reset_n),
    .vsync     (vsync),
    .period_we (hit && (op == OP_PERIOD)),
    .period_in (cw.payload[7:0]),
    .frame     (frame)
  );

endmodule

// File: tb/tb_sprite_bank.sv
// Directed bench for sprite_bank (INDEX=0, SIZE=16, FRAMES=4).
module tb_sprite_bank;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] control;
  logic        vsync;
  logic [3:0]  x, y;
  logic [31:0] rgba;
  logic [3:0]  frame;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sprite_bank #(.INDEX(0), .SIZE(16), .FRAMES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .control   (control),
    .vsync     (vsync),
    .x         (x),
    .y         (y),
    .rgba      (rgba),
    .frame     (frame)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cmd(input logic [3:0] op, input logic [7:0] idx,
                                      input logic [3:0] cx, input logic [3:0] cy,
                                      input logic [11:0] pl);
    return {op, idx, cx, cy, pl};
  endfunction

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    control   = w;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      cyc();
      n++;
    end
    if (n >= 2000) check("send_ready_timeout", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] cx, input logic [3:0] cy,
                            input logic [31:0] exp);
    x = cx;
    y = cy;
    cyc();
    check(tag, rgba, exp);
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    cyc();
    vsync = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    control   = 32'h0;
    vsync     = 1'b0;
    x         = 4'd0;
    y         = 4'd0;
    cyc();
    cyc();
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_frame", 32'(frame), 32'd0);
    check("reset_rgba", rgba, 32'h0);
    reset_n = 1'b1;
    cyc();

    // CLEAR frame 0 with a WRITE held behind it
    control   = cmd(OP_CLEAR, 8'd0, 4'd0, 4'd0, 12'h000);
    cmd_valid = 1'b1;
    cyc();
    control = cmd(OP_WRITE, 8'd0, 4'd3, 4'd5, 12'hF80);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 1000) begin
      cyc();
      n++;
    end
    check("clear_busy_cycles", 32'(n), 32'd256);
    cyc();
    cmd_valid = 1'b0;
    read_check("held_write_3_5", 4'd3, 4'd5, 32'hF08000FF);
    read_check("clear_0_0", 4'd0, 4'd0, 32'h0);
    read_check("clear_15_15", 4'd15, 4'd15, 32'h0);
    read_check("clear_7_9", 4'd7, 4'd9, 32'h0);

    // Foreign index is ignored
    send(cmd(OP_WRITE, 8'd1, 4'd3, 4'd5, 12'h00F));
    read_check("other_index_ignored", 4'd3, 4'd5, 32'hF08000FF);

    // Read-before-write on the same address
    x = 4'd3;
    y = 4'd5;
    send(cmd(OP_WRITE, 8'd0, 4'd3, 4'd5, 12'h555));
    check("rbw_old_data", rgba, 32'hF08000FF);
    cyc();
    check("rbw_new_data", rgba, 32'h505050FF);

    // Populate frames 0, 1, 2
    send(cmd(OP_WRITE, 8'd0, 4'd0, 4'd0, 12'hABC));
    send(cmd(OP_WRITE, 8'd0, 4'd15, 4'd15, 12'h777));
    send(cmd(OP_SELECT, 8'd0, 4'd0, 4'd0, 12'h001));
    send(cmd(OP_CLEAR, 8'd0, 4'd0, 4'd0, 12'h000));
    send(cmd(OP_WRITE, 8'd0, 4'd0, 4'd0, 12'h123));
    send(cmd(OP_SELECT, 8'd0, 4'd0, 4'd0, 12'h006));
    send(cmd(OP_WRITE, 8'd0, 4'd0, 4'd0, 12'h00F));
    send(cmd(OP_PERIOD, 8'd0, 4'd0, 4'd0, 12'h001));
    pulse_vsync();
    check("p1_frame_a", 32'(frame), 32'd1);
    pulse_vsync();
    check("p1_frame_b", 32'(frame), 32'd2);
    read_check("frame2_0_0", 4'd0, 4'd0, 32'h0000F0FF);
    pulse_vsync();
    pulse_vsync();
    check("p1_frame_wrap", 32'(frame), 32'd0);
    read_check("frame0_0_0", 4'd0, 4'd0, 32'hA0B0C0FF);
    pulse_vsync();
    read_check("frame1_0_0", 4'd0, 4'd0, 32'h102030FF);

    // Reset in the middle of a CLEAR of frame 0
    send(cmd(OP_SELECT, 8'd0, 4'd0, 4'd0, 12'h000));
    send(cmd(OP_CLEAR, 8'd0, 4'd0, 4'd0, 12'h000));
    repeat (99) cyc();
    x = 4'd15;
    y = 4'd15;
    reset_n = 1'b0;
    cyc();
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_frame", 32'(frame), 32'd0);
    check("abort_rgba", rgba, 32'h0);
    reset_n = 1'b1;
    read_check("abort_0_0_cleared", 4'd0, 4'd0, 32'h0);
    read_check("abort_3_5_cleared", 4'd3, 4'd5, 32'h0);
    read_check("abort_15_15_kept", 4'd15, 4'd15, 32'h707070FF);

    // PERIOD 3: frame steps on every third pulse
    send(cmd(OP_PERIOD, 8'd0, 4'd0, 4'd0, 12'h003));
    for (int i = 1; i <= 12; i++) begin
      pulse_vsync();
      check($sformatf("p3_pulse_%0d", i), 32'(frame), 32'((i / 3) % 4));
    end
    send(cmd(OP_PERIOD, 8'd0, 4'd0, 4'd0, 12'h000));
    repeat (3) pulse_vsync();
    check("p0_frozen", 32'(frame), 32'd0);

    // A PERIOD write restarts the tick count
    send(cmd(OP_PERIOD, 8'd0, 4'd0, 4'd0, 12'h003));
    repeat (2) pulse_vsync();
    send(cmd(OP_PERIOD, 8'd0, 4'd0, 4'd0, 12'h003));
    repeat (2) pulse_vsync();
    check("tick_restart_hold", 32'(frame), 32'd0);
    pulse_vsync();
    check("tick_restart_step", 32'(frame), 32'd1);

    // Mirroring on frame 1
    send(cmd(OP_SELECT, 8'd0, 4'd0, 4'd0, 12'h001));
    send(cmd(OP_WRITE, 8'd0, 4'd0, 4'd0, 12'hFFF));
    send(cmd(OP_WRITE, 8'd0, 4'd15, 4'd0, 12'h321));
    send(cmd(OP_FLIP, 8'd0, 4'd0, 4'd0, 12'h001));
`ifdef SPRITE_FLIP_EN
    read_check("flip_15_0", 4'd15, 4'd0, 32'hF0F0F0FF);
    read_check("flip_0_0", 4'd0, 4'd0, 32'h302010FF);
`else
    read_check("noflip_15_0", 4'd15, 4'd0, 32'h302010FF);
    read_check("noflip_0_0", 4'd0, 4'd0, 32'hF0F0F0FF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
